// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU demo sequencer: FSM state encoding, bus widths
// and the operand/opcode vector with its sweep-advance helper.
package alu_seq_pkg;

   localparam int OP_W    = 3;
   localparam int DATA_W  = 4;
   localparam int VEC_W   = 2 * DATA_W + OP_W;
   localparam int TIMER_W = 27;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DWELL = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op_code;
   } vec_t;

   // A:B:opCode behaves as one counter, so the sweep is a plain increment.
   function automatic vec_t next_vec(input vec_t v);
      logic [VEC_W-1:0] flat;
      flat = v;
      flat = flat + VEC_W'(1);
      return vec_t'(flat);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Free-running up-counter with synchronous clear and a match flag against
// a runtime limit; shared by the dwell and ack-timeout functions.
module cycle_timer
   import alu_seq_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic         match
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q + W'(1);
      if (clear) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign match = (count_q == limit);

endmodule

// File: rtl/alu_demo_sequencer.sv
// Owns the ALU operand/opcode bus: forwards manual selections or sweeps all
// vectors in AUTO mode, holding each one until the LCD acknowledges a redraw.
module alu_demo_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES   = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              auto_en,
   input  logic              step,
   input  logic [DATA_W-1:0] man_a,
   input  logic [DATA_W-1:0] man_b,
   input  logic [OP_W-1:0]   man_op,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [OP_W-1:0]   opCode,
   output logic              lcd_req,
   input  logic              lcd_ack,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [TIMER_W-1:0] DWELL_LIMIT   = TIMER_W'(DWELL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

   state_t state_q, state_d;
   vec_t   vec_q, vec_d;
   logic   err_q, err_d;
   vec_t   man_vec;

   logic               timer_clear;
   logic               timer_match;
   logic [TIMER_W-1:0] timer_limit;

   assign man_vec = {man_a, man_b, man_op};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (auto_en) begin
               state_d = REQ;
            end else if (man_vec != vec_q) begin
               vec_d   = man_vec;
               state_d = REQ;
            end
         end
         REQ: begin
            // Ack takes priority over a coincident expiry, so no error then.
            if (lcd_ack || timer_match) begin
               state_d = auto_en ? DWELL : IDLE;
               if (!lcd_ack) begin
                  err_d = 1'b1;
               end
            end
         end
         DWELL: begin
            if (!auto_en) begin
               state_d = IDLE;
            end else if (timer_match || step) begin
               vec_d   = next_vec(vec_q);
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      lcd_req = (state_q == REQ);
      busy    = (state_q != IDLE);
   end

   // Only one of dwell/timeout is ever live, so one timer serves both.
   assign timer_clear = (state_d != state_q) || (state_q == IDLE);
   assign timer_limit = (state_q == DWELL) ? DWELL_LIMIT : TIMEOUT_LIMIT;

   cycle_timer #(
      .W(TIMER_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(timer_clear),
      .limit(timer_limit),
      .match(timer_match)
   );

   assign A           = vec_q.a;
   assign B           = vec_q.b;
   assign opCode      = vec_q.op_code;
   assign timeout_err = err_q;

endmodule
